// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STAGE,
    S_RUN
  } state_t;

  localparam int LOCK_CNT_W = 8;

  function automatic int cnt_width(input int x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync_2ff.sv
// Single-bit two-flop synchroniser with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Board reset/startup sequencer: PLL reset pulse, then staged release of N reset domains.
// Optional WAIT_LOCK timeout with PLL re-pulse is enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES        = 4,
  parameter int PLL_RST_CYCLES  = 4,
  parameter int STAGE_DELAY     = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOCK_TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_rst_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [N_STAGES-1:0]   rst_out_n,
  output logic                  seq_done,
  output logic [LOCK_CNT_W-1:0] lock_lost_cnt,
  output logic                  lock_timeout
);

  localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int PLL_W   = cnt_width(PLL_RST_CYCLES);
  localparam int STAGE_W = cnt_width(STAGE_DELAY);
  localparam int IDX_W   = cnt_width(N_STAGES);

  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PLL_W-1:0]   PLL_LAST   = PLL_W'(PLL_RST_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_STAGES - 1);

  logic key_s;
  logic lock_s;

  sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_rst_n),
    .q     (key_s)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Press latches once the low run reaches DEBOUNCE_CYCLES and holds while the key stays low.
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             press_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_reg <= '0;
      press_reg   <= 1'b0;
    end else if (key_s) begin
      deb_cnt_reg <= '0;
      press_reg   <= 1'b0;
    end else if (deb_cnt_reg != DEB_MAX) begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
      press_reg   <= (deb_cnt_reg == DEB_LAST);
    end
  end

  state_t                  state_reg, state_next;
  logic [PLL_W-1:0]        pll_cnt_reg, pll_cnt_next;
  logic [STAGE_W-1:0]      stage_cnt_reg, stage_cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    pll_rst_reg, pll_rst_next;
  logic [N_STAGES-1:0]     rst_out_reg, rst_out_next;
  logic                    seq_done_reg, seq_done_next;
  logic [LOCK_CNT_W-1:0]   lost_reg, lost_next;
  logic [N_STAGES-1:0]     stage_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage_sel
      assign stage_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int               TO_W    = cnt_width(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            timeout_reg, timeout_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      to_cnt_reg  <= to_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign lock_timeout = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^LOCK_TIMEOUT;
  assign lock_timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_PLL_RST;
      pll_cnt_reg   <= '0;
      stage_cnt_reg <= '0;
      idx_reg       <= '0;
      pll_rst_reg   <= 1'b1;
      rst_out_reg   <= '0;
      seq_done_reg  <= 1'b0;
      lost_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      pll_cnt_reg   <= pll_cnt_next;
      stage_cnt_reg <= stage_cnt_next;
      idx_reg       <= idx_next;
      pll_rst_reg   <= pll_rst_next;
      rst_out_reg   <= rst_out_next;
      seq_done_reg  <= seq_done_next;
      lost_reg      <= lost_next;
    end
  end

  // Priority: button press, then lock loss (only once staging has begun), then normal progress.
  always_comb begin
    state_next     = state_reg;
    pll_cnt_next   = pll_cnt_reg;
    stage_cnt_next = stage_cnt_reg;
    idx_next       = idx_reg;
    pll_rst_next   = pll_rst_reg;
    rst_out_next   = rst_out_reg;
    seq_done_next  = seq_done_reg;
    lost_next      = lost_reg;
`ifdef RESET_SEQ_TIMEOUT_EN
    to_cnt_next    = '0;
    timeout_next   = 1'b0;
`endif
    if (press_reg) begin
      state_next    = S_PLL_RST;
      pll_cnt_next  = '0;
      pll_rst_next  = 1'b1;
      rst_out_next  = '0;
      seq_done_next = 1'b0;
    end else if ((state_reg == S_STAGE || state_reg == S_RUN) && !lock_s) begin
      state_next    = S_WAIT_LOCK;
      rst_out_next  = '0;
      seq_done_next = 1'b0;
      if (lost_reg != '1) begin
        lost_next = lost_reg + 1'b1;
      end
    end else begin
      case (state_reg)
        S_PLL_RST: begin
          if (pll_cnt_reg == PLL_LAST) begin
            state_next   = S_WAIT_LOCK;
            pll_cnt_next = '0;
            pll_rst_next = 1'b0;
          end else begin
            pll_cnt_next = pll_cnt_reg + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_next     = S_STAGE;
            idx_next       = '0;
            stage_cnt_next = '0;
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (to_cnt_reg == TO_LAST) begin
            state_next   = S_PLL_RST;
            pll_cnt_next = '0;
            pll_rst_next = 1'b1;
            timeout_next = 1'b1;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
`endif
        end
        S_STAGE: begin
          if (stage_cnt_reg == STAGE_LAST) begin
            stage_cnt_next = '0;
            rst_out_next   = rst_out_reg | stage_sel;
            if (idx_reg == IDX_LAST) begin
              state_next    = S_RUN;
              seq_done_next = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            stage_cnt_next = stage_cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
        end
        default: begin
          state_next = S_PLL_RST;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign rst_out_n     = rst_out_reg;
  assign seq_done      = seq_done_reg;
  assign lock_lost_cnt = lost_reg;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: per-cycle comparison against a time-based model plus literal latency checks.
module tb_reset_seq;

  localparam int N    = 4;
  localparam int PLLC = 4;
  localparam int SD   = 8;
  localparam int DEB  = 4;
  localparam int LT   = 32;

  localparam int PH_PLL  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_SEQ  = 2;
  localparam int PH_RUN  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       lock;
  logic       pll_rst;
  logic [3:0] rst_out_n;
  logic       seq_done;
  logic [7:0] lost;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int cyc;
  int pll_hi_cnt = 0;
  bit run_cmp = 1'b0;

  always #10 clk = ~clk;

  reset_seq #(
    .N_STAGES        (N),
    .PLL_RST_CYCLES  (PLLC),
    .STAGE_DELAY     (SD),
    .DEBOUNCE_CYCLES (DEB),
    .LOCK_TIMEOUT    (LT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_rst_n     (key),
    .pll_locked    (lock),
    .pll_rst       (pll_rst),
    .rst_out_n     (rst_out_n),
    .seq_done      (seq_done),
    .lock_lost_cnt (lost),
    .lock_timeout  (timeout)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Model: phase plus cycles-in-phase; released stages follow from elapsed time.
  int   m_phase, m_t, m_low, m_lost;
  bit   m_press, m_to;
  logic k1, k2, l1, l2;

  always @(posedge clk or negedge rst_n) begin : model_step
    bit p;
    bit l;
    if (!rst_n) begin
      m_phase = PH_PLL; m_t = 0; m_low = 0; m_lost = 0;
      m_press = 1'b0; m_to = 1'b0;
      k1 = 1'b1; k2 = 1'b1; l1 = 1'b0; l2 = 1'b0;
    end else begin
      p = m_press;
      l = l2;
      m_to = 1'b0;
      if (k2) m_low = 0;
      else if (m_low < DEB) m_low++;
      m_press = (m_low >= DEB);
      k2 = k1; k1 = key;
      l2 = l1; l1 = lock;
      if (p) begin
        m_phase = PH_PLL; m_t = 0;
      end else if ((m_phase == PH_SEQ || m_phase == PH_RUN) && !l) begin
        m_phase = PH_WAIT; m_t = 0;
        if (m_lost < 255) m_lost++;
      end else begin
        case (m_phase)
          PH_PLL: begin
            m_t++;
            if (m_t == PLLC) begin m_phase = PH_WAIT; m_t = 0; end
          end
          PH_WAIT: begin
            if (l) begin m_phase = PH_SEQ; m_t = 0; end
`ifdef RESET_SEQ_TIMEOUT_EN
            else begin
              m_t++;
              if (m_t == LT) begin m_to = 1'b1; m_phase = PH_PLL; m_t = 0; end
            end
`endif
          end
          PH_SEQ: begin
            m_t++;
            if (m_t == N * SD) m_phase = PH_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [14:0] model_vec();
    logic [3:0] ro;
    int n;
    ro = 4'b0000;
    if (m_phase == PH_RUN) ro = 4'hF;
    else if (m_phase == PH_SEQ) begin
      n  = m_t / SD;
      ro = 4'((1 << n) - 1);
    end
    return {(m_phase == PH_PLL), ro, (m_phase == PH_RUN), 8'(m_lost), m_to};
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if ({pll_rst, rst_out_n, seq_done, lost, timeout} !== model_vec()) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d got=%h want=%h", cyc,
                 {pll_rst, rst_out_n, seq_done, lost, timeout}, model_vec());
      end
      if (pll_rst) pll_hi_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_out(input logic [3:0] pat, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rst_out_n === pat) begin at = cyc; break; end
    end
  endtask

  task automatic wait_pll(input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pll_rst === val) begin at = cyc; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at, c0, snap, to_cnt, to_first, to_second, pll_w;
    rst_n = 1'b0; key = 1'b1; lock = 1'b1;
    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_rst_out", rst_out_n, 0);
    chk("reset_seq_done", seq_done, 0);
    rst_n = 1'b1;

    // 1: power-up sequence
    wait_pll(1'b0, 20, at);     chk("t1_pll_rst_fall", at, 4);
    wait_out(4'b0001, 40, at);  chk("t1_stage0", at, 13);
    wait_out(4'b0011, 40, at);  chk("t1_stage1", at, 21);
    wait_out(4'b0111, 40, at);  chk("t1_stage2", at, 29);
    wait_out(4'b1111, 40, at);  chk("t1_stage3", at, 37);
    chk("t1_seq_done", seq_done, 1);

    // 2: short press ignored, full press restarts
    repeat (5) @(negedge clk);
    key = 1'b0; repeat (3) @(negedge clk); key = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_short_rst_out", rst_out_n, 15);
    chk("t2_short_pll_rst", pll_rst, 0);
    c0 = cyc;
    key = 1'b0; repeat (4) @(negedge clk); key = 1'b1;
    wait_pll(1'b1, 20, at);     chk("t2_press_latency", at - c0, 7);
    chk("t2_press_rst_out", rst_out_n, 0);
    wait_out(4'b1111, 80, at);  chk("t2_restage_latency", at - c0, 44);

    // 3: one-cycle lock loss
    repeat (5) @(negedge clk);
    snap = pll_hi_cnt;
    c0 = cyc;
    lock = 1'b0; @(negedge clk); lock = 1'b1;
    wait_out(4'b0000, 10, at);  chk("t3_drop_latency", at - c0, 3);
    chk("t3_lost_cnt", lost, 1);
    wait_out(4'b1111, 60, at);  chk("t3_restage_latency", at - c0, 36);
    chk("t3_no_pll_pulse", pll_hi_cnt - snap, 0);

    // 5: press completes as synced lock drops
    repeat (5) @(negedge clk);
    c0 = cyc;
    key = 1'b0; repeat (4) @(negedge clk); key = 1'b1; lock = 1'b0;
    wait_pll(1'b1, 20, at);     chk("t5_press_latency", at - c0, 7);
    chk("t5_lost_unchanged", lost, 1);
    chk("t5_rst_out", rst_out_n, 0);
    repeat (15) @(negedge clk);
    lock = 1'b1;
    wait_out(4'b1111, 100, at); chk("t5_restaged", rst_out_n, 15);
    chk("t5_lost_final", lost, 1);

    // 4: asynchronous reset mid-sequence
    repeat (3) @(negedge clk);
    lock = 1'b0; @(negedge clk); lock = 1'b1;
    wait_out(4'b0011, 60, at);  chk("t4_reached_0011", rst_out_n, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_pll_rst", pll_rst, 1);
    chk("t4_rst_out", rst_out_n, 0);
    chk("t4_seq_done", seq_done, 0);
    chk("t4_lost", lost, 0);
    chk("t4_timeout", timeout, 0);
    lock = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 6: no lock after reset
    to_cnt = 0; to_first = -1; to_second = -1; pll_w = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (timeout) begin
        to_cnt++;
        if (to_first < 0) to_first = cyc;
        else if (to_second < 0) to_second = cyc;
      end
      if (cyc >= 4 && pll_rst) pll_w++;
    end
`ifdef RESET_SEQ_TIMEOUT_EN
    chk("t6_timeout_first", to_first, 36);
    chk("t6_timeout_second", to_second, 72);
    chk("t6_timeout_count", to_cnt, 2);
    chk("t6_pll_pulse_cycles", pll_w, 8);
`else
    chk("t6_timeout_count", to_cnt, 0);
    chk("t6_pll_pulse_cycles", pll_w, 0);
    chk("t6_rst_out_held", rst_out_n, 0);
`endif
    lock = 1'b1;
    wait_out(4'b1111, 120, at); chk("t6_final_rst_out", rst_out_n, 15);
    chk("t6_final_seq_done", seq_done, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
